// File: rtl/stream_in_port_geom_pkg.sv
// Shared types and constants for the stream_in_port_geom ingress port.
//   state_t   : ingress FSM states (WAIT_SOF, ACTIVE, DISCARD)
//   cnt_op_t  : operation requested from the geometry counter on a beat
//   CNT_W     : width of the line/beat counters and geometry inputs
//   MODE_* / FS_* : legal values of the MODE and FRAME_SYNC parameters
package stream_in_pkg;

    localparam int CNT_W = 16;

    localparam string MODE_LINE = "LINE";
    localparam string MODE_ONCE = "ONCE";
    localparam string FS_ON     = "ON";
    localparam string FS_OFF    = "OFF";

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        DISCARD  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_LINE = 2'd2,
        CNT_CLR  = 2'd3
    } cnt_op_t;

endpackage

// File: rtl/stream_in_port_geom_if.sv
// AXI4-Stream video bus between a video source and stream_in_port_geom.
//   axi_tdata  : pixel data (DSIZE bits)
//   axi_tvalid : source has a beat
//   axi_tready : port can accept a beat
//   axi_tuser  : start of frame
//   axi_tlast  : end of line
// master = video source, slave = ingress port.
interface stream_in_port_geom_if #(
    parameter int DSIZE = 24
);
    logic [DSIZE-1:0] axi_tdata;
    logic             axi_tvalid;
    logic             axi_tready;
    logic             axi_tuser;
    logic             axi_tlast;

    modport master (
        output axi_tdata, axi_tvalid, axi_tuser, axi_tlast,
        input  axi_tready
    );

    modport slave (
        input  axi_tdata, axi_tvalid, axi_tuser, axi_tlast,
        output axi_tready
    );
endinterface

// File: rtl/stream_in_port_geom_geom_counter.sv
// Beat/line counters for stream_in_port_geom plus the latched frame geometry.
//   aclk, aresetn, aclken : clock, sync active-low reset, clock enable
//   load_i                : SOF beat with valid geometry; latch hactive_i/vactive_i
//   hactive_i, vactive_i  : live geometry inputs
//   tlast_i               : tlast of the current beat
//   op_i                  : counter update for this beat
//   line_done_o           : current beat ends the line (tlast or hactive reached)
//   frame_done_o          : current line is the last line of the frame
//   short_line_o          : tlast before hactive beats
//   long_line_o           : hactive reached without tlast
module geom_counter
    import stream_in_pkg::*;
(
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             aclken,
    input  logic             load_i,
    input  logic [CNT_W-1:0] hactive_i,
    input  logic [CNT_W-1:0] vactive_i,
    input  logic             tlast_i,
    input  cnt_op_t          op_i,
    output logic             line_done_o,
    output logic             frame_done_o,
    output logic             short_line_o,
    output logic             long_line_o
);

    logic [CNT_W-1:0] hact_q, hact_d, vact_q, vact_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [CNT_W-1:0] h_eff, v_eff, hc_eff, vc_eff, h_last, v_last;

    // An SOF beat is evaluated as the first beat of a fresh frame using the
    // incoming geometry, so its flags are correct in the same cycle.
    always_comb begin
        h_eff  = load_i ? hactive_i : hact_q;
        v_eff  = load_i ? vactive_i : vact_q;
        hc_eff = load_i ? '0 : hcnt_q;
        vc_eff = load_i ? '0 : vcnt_q;
        h_last = h_eff - CNT_W'(1);
        v_last = v_eff - CNT_W'(1);

        line_done_o  = tlast_i | (hc_eff == h_last);
        frame_done_o = (vc_eff == v_last);
        short_line_o = tlast_i & (hc_eff < h_last);
        long_line_o  = ~tlast_i & (hc_eff == h_last);

        hact_d = h_eff;
        vact_d = v_eff;
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        case (op_i)
            CNT_INC: begin
                hcnt_d = hc_eff + CNT_W'(1);
                vcnt_d = vc_eff;
            end
            CNT_LINE: begin
                hcnt_d = '0;
                vcnt_d = vc_eff + CNT_W'(1);
            end
            CNT_CLR: begin
                hcnt_d = '0;
                vcnt_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            hact_q <= '0;
            vact_q <= '0;
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else if (aclken) begin
            hact_q <= hact_d;
            vact_q <= vact_d;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

endmodule

// File: rtl/stream_in_port_geom.sv
// AXI4-Stream video ingress port with SOF lock-on and line geometry checks.
//   aclk, aresetn, aclken   : clock, sync active-low reset, clock enable
//   vactive, hactive        : frame geometry, sampled at SOF
//   fsync                   : external frame sync (FRAME_SYNC="ON")
//   fifo_almost_full        : downstream backpressure
//   s_axis                  : AXI4-Stream slave (tdata/tvalid/tready/tuser/tlast)
//   falign/lalign/ealign    : frame start / line end / frame end pulses
//   odata_vld, odata        : registered accepted data
//   err_short/err_long/err_early_sof : geometry error pulses
module stream_in_port_geom
    import stream_in_pkg::*;
#(
    parameter int    DSIZE      = 24,
    parameter string MODE       = "LINE",
    parameter string FRAME_SYNC = "OFF"
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 aclken,
    input  logic [CNT_W-1:0]     vactive,
    input  logic [CNT_W-1:0]     hactive,
    input  logic                 fsync,
    input  logic                 fifo_almost_full,
    stream_in_port_geom_if.slave s_axis,
    output logic                 falign,
    output logic                 lalign,
    output logic                 ealign,
    output logic                 odata_vld,
    output logic [DSIZE-1:0]     odata,
    output logic                 err_short,
    output logic                 err_long,
    output logic                 err_early_sof
);

    localparam bit LINE_MODE = (MODE == MODE_LINE);
    localparam bit FS_EXT    = (FRAME_SYNC == FS_ON);

    state_t           state_q, state_d;
    logic             tready_q, arm_q, arm_d, disc_end_q, disc_end_d;
    logic             vld_q, falign_q, lalign_q, ealign_q;
    logic             short_q, long_q, early_q;
    logic             lalign_d, ealign_d, short_d, long_d;
    logic [DSIZE-1:0] odata_q;
    logic             beat, sof, geom_ok, sof_beat, load, take;
    logic             line_done, frame_done, short_line, long_line;
    cnt_op_t          cnt_op;

    assign beat     = s_axis.axi_tvalid & tready_q & aclken;
    assign sof      = FS_EXT ? arm_q : s_axis.axi_tuser;
    assign geom_ok  = (hactive != '0) & (vactive != '0);
    assign sof_beat = beat & sof;
    assign load     = sof_beat & geom_ok;
    // Beats forwarded downstream: a valid SOF, or any in-frame beat.
    assign take     = load | (beat & ~sof & (state_q == ACTIVE));
    // Arm is set by fsync and consumed by the SOF beat; fsync while armed is a no-op.
    assign arm_d    = FS_EXT & ~sof_beat & (arm_q | fsync);

    geom_counter u_geom (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .aclken      (aclken),
        .load_i      (load),
        .hactive_i   (hactive),
        .vactive_i   (vactive),
        .tlast_i     (s_axis.axi_tlast),
        .op_i        (cnt_op),
        .line_done_o (line_done),
        .frame_done_o(frame_done),
        .short_line_o(short_line),
        .long_line_o (long_line)
    );

    always_comb begin
        state_d    = state_q;
        disc_end_d = disc_end_q;
        cnt_op     = CNT_HOLD;
        lalign_d   = 1'b0;
        ealign_d   = 1'b0;
        short_d    = 1'b0;
        long_d     = 1'b0;
        if (take) begin
            if (line_done) begin
                lalign_d = LINE_MODE;
                ealign_d = frame_done;
                short_d  = short_line;
                long_d   = long_line;
                cnt_op   = frame_done ? CNT_CLR : CNT_LINE;
                if (long_line) begin
                    // Rest of an over-long line is dropped up to its tlast;
                    // remember whether the frame is over once that arrives.
                    state_d    = DISCARD;
                    disc_end_d = frame_done;
                end else begin
                    state_d = frame_done ? WAIT_SOF : ACTIVE;
                end
            end else begin
                cnt_op  = CNT_INC;
                state_d = ACTIVE;
            end
        end else if (sof_beat) begin
            // SOF with zero geometry: drop it and wait for a usable frame.
            cnt_op  = CNT_CLR;
            state_d = WAIT_SOF;
        end else if (beat && state_q == DISCARD && s_axis.axi_tlast) begin
            state_d = disc_end_q ? WAIT_SOF : ACTIVE;
        end
    end

    // Output register stage: everything lags the accepted beat by one cycle.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= WAIT_SOF;
            tready_q   <= 1'b0;
            arm_q      <= 1'b0;
            disc_end_q <= 1'b0;
            vld_q      <= 1'b0;
            falign_q   <= 1'b0;
            lalign_q   <= 1'b0;
            ealign_q   <= 1'b0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            early_q    <= 1'b0;
            odata_q    <= '0;
        end else if (aclken) begin
            state_q    <= state_d;
            tready_q   <= ~fifo_almost_full;
            arm_q      <= arm_d;
            disc_end_q <= disc_end_d;
            vld_q      <= take;
            falign_q   <= load;
            lalign_q   <= lalign_d;
            ealign_q   <= ealign_d;
            short_q    <= short_d;
            long_q     <= long_d;
            early_q    <= sof_beat & (state_q != WAIT_SOF);
            if (take) odata_q <= s_axis.axi_tdata;
        end else begin
            vld_q    <= 1'b0;
            falign_q <= 1'b0;
            lalign_q <= 1'b0;
            ealign_q <= 1'b0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            early_q  <= 1'b0;
        end
    end

    assign s_axis.axi_tready = tready_q;
    assign odata_vld         = vld_q;
    assign odata             = odata_q;
    assign falign            = falign_q;
    assign lalign            = lalign_q;
    assign ealign            = ealign_q;
    assign err_short         = short_q;
    assign err_long          = long_q;
    assign err_early_sof     = early_q;

endmodule

// File: tb/tb_stream_in_port_geom.sv
// Bench for stream_in_port_geom: one instance per FRAME_SYNC setting, both
// driven by the same stimulus and each compared every cycle with a
// frame/line reference model; plus table vectors and directed sequences.
module tb_stream_in_port_geom;
    localparam int DW = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn, aclken, fsync, afull, tvalid, tuser, tlast;
    logic [DW-1:0] tdata;
    logic [15:0]   hact, vact;

    stream_in_port_geom_if #(.DSIZE(DW)) if_off ();
    stream_in_port_geom_if #(.DSIZE(DW)) if_on ();

    assign if_off.axi_tdata  = tdata;
    assign if_off.axi_tvalid = tvalid;
    assign if_off.axi_tuser  = tuser;
    assign if_off.axi_tlast  = tlast;
    assign if_on.axi_tdata   = tdata;
    assign if_on.axi_tvalid  = tvalid;
    assign if_on.axi_tuser   = tuser;
    assign if_on.axi_tlast   = tlast;

    logic          vld_w [2];
    logic          fa_w [2];
    logic          la_w [2];
    logic          ea_w [2];
    logic          es_w [2];
    logic          el_w [2];
    logic          ee_w [2];
    logic [DW-1:0] od_w [2];

    stream_in_port_geom #(.DSIZE(DW), .MODE("LINE"), .FRAME_SYNC("OFF")) dut_off (
        .aclk(clk), .aresetn(rstn), .aclken(aclken), .vactive(vact), .hactive(hact),
        .fsync(fsync), .fifo_almost_full(afull), .s_axis(if_off),
        .falign(fa_w[0]), .lalign(la_w[0]), .ealign(ea_w[0]), .odata_vld(vld_w[0]),
        .odata(od_w[0]), .err_short(es_w[0]), .err_long(el_w[0]), .err_early_sof(ee_w[0])
    );

    stream_in_port_geom #(.DSIZE(DW), .MODE("LINE"), .FRAME_SYNC("ON")) dut_on (
        .aclk(clk), .aresetn(rstn), .aclken(aclken), .vactive(vact), .hactive(hact),
        .fsync(fsync), .fifo_almost_full(afull), .s_axis(if_on),
        .falign(fa_w[1]), .lalign(la_w[1]), .ealign(ea_w[1]), .odata_vld(vld_w[1]),
        .odata(od_w[1]), .err_short(es_w[1]), .err_long(el_w[1]), .err_early_sof(ee_w[1])
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        else
            passed++;
    endtask

    // Reference model, index 0 = tuser SOF, index 1 = fsync-armed SOF.
    // A frame is tracked as "beats taken in this line" and "lines finished".
    bit            m_rdy [2];
    bit            m_arm [2];
    bit            m_in [2];
    bit            m_skip [2];
    bit            m_skend [2];
    int            m_pos [2];
    int            m_line [2];
    int            m_H [2];
    int            m_V [2];
    bit            x_vld [2];
    bit            x_fa [2];
    bit            x_la [2];
    bit            x_ea [2];
    bit            x_es [2];
    bit            x_el [2];
    bit            x_ee [2];
    logic [DW-1:0] x_od [2];

    function automatic void clear_pulses(int m);
        x_vld[m] = 0; x_fa[m] = 0; x_la[m] = 0; x_ea[m] = 0;
        x_es[m] = 0; x_el[m] = 0; x_ee[m] = 0;
    endfunction

    function automatic void model_step(int m);
        bit beat, sof, take;
        if (!rstn) begin
            clear_pulses(m);
            x_od[m] = '0; m_rdy[m] = 0; m_arm[m] = 0; m_in[m] = 0;
            m_skip[m] = 0; m_skend[m] = 0; m_pos[m] = 0; m_line[m] = 0;
            return;
        end
        clear_pulses(m);
        if (!aclken) return;
        beat = tvalid && m_rdy[m];
        m_rdy[m] = !afull;
        sof = (m == 1) ? m_arm[m] : tuser;
        if (m == 1) begin
            if (beat && m_arm[m]) m_arm[m] = 0;
            else if (fsync) m_arm[m] = 1;
        end
        take = 0;
        if (beat) begin
            if (sof) begin
                x_ee[m] = m_in[m];
                if (hact == 0 || vact == 0) begin
                    m_in[m] = 0; m_skip[m] = 0;
                end else begin
                    m_H[m] = int'(hact); m_V[m] = int'(vact);
                    m_pos[m] = 0; m_line[m] = 0;
                    m_in[m] = 1; m_skip[m] = 0;
                    x_fa[m] = 1; take = 1;
                end
            end else if (m_in[m] && !m_skip[m]) begin
                take = 1;
            end else if (m_skip[m] && tlast) begin
                m_skip[m] = 0;
                if (m_skend[m]) m_in[m] = 0;
            end
        end
        if (take) begin
            x_vld[m] = 1;
            x_od[m] = tdata;
            m_pos[m]++;
            if (tlast) begin
                x_es[m] = (m_pos[m] < m_H[m]);
                x_la[m] = 1;
                m_line[m]++; m_pos[m] = 0;
                if (m_line[m] == m_V[m]) begin
                    x_ea[m] = 1; m_in[m] = 0;
                end
            end else if (m_pos[m] == m_H[m]) begin
                x_la[m] = 1; x_el[m] = 1;
                m_line[m]++; m_pos[m] = 0;
                m_skip[m] = 1;
                m_skend[m] = (m_line[m] == m_V[m]);
                x_ea[m] = m_skend[m];
            end
        end
    endfunction

    function automatic logic [31:0] pack_act(int m);
        logic rdy;
        rdy = (m == 0) ? if_off.axi_tready : if_on.axi_tready;
        return {rdy, vld_w[m], fa_w[m], la_w[m], ea_w[m], es_w[m], el_w[m], ee_w[m], od_w[m]};
    endfunction

    function automatic logic [31:0] pack_exp(int m);
        return {m_rdy[m], x_vld[m], x_fa[m], x_la[m], x_ea[m], x_es[m], x_el[m], x_ee[m], x_od[m]};
    endfunction

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check("cycle_model_off", pack_act(0), pack_exp(0));
        check("cycle_model_on", pack_act(1), pack_exp(1));
    endtask

    typedef struct {
        bit       u;
        bit       l;
        bit [6:0] exp;   // {vld, falign, lalign, ealign, err_short, err_long, err_early_sof}
    } vec_t;

    vec_t vecs [38];

    initial begin
        rstn = 0; aclken = 1; fsync = 0; afull = 0;
        tvalid = 0; tuser = 0; tlast = 0; tdata = '0;
        hact = 16'd4; vact = 16'd2;

        tick();
        tick();
        check("reset_state_off", pack_act(0), 32'h0);
        check("reset_state_on", pack_act(1), 32'h0);
        rstn = 1;
        tick();
        check("tready_after_reset", 32'(if_off.axi_tready), 32'd1);

        vecs = '{
            // clean frame, tlast on beats 3 and 7
            '{1,0,7'b1100000}, '{0,0,7'b1000000}, '{0,0,7'b1000000}, '{0,1,7'b1010000},
            '{0,0,7'b1000000}, '{0,0,7'b1000000}, '{0,0,7'b1000000}, '{0,1,7'b1011000},
            // short first line, full second line
            '{1,0,7'b1100000}, '{0,0,7'b1000000}, '{0,1,7'b1010100},
            '{0,0,7'b1000000}, '{0,0,7'b1000000}, '{0,0,7'b1000000}, '{0,1,7'b1011000},
            // 6-beat line truncated, then normal last line
            '{1,0,7'b1100000}, '{0,0,7'b1000000}, '{0,0,7'b1000000}, '{0,0,7'b1010010},
            '{0,0,7'b0000000}, '{0,1,7'b0000000},
            '{0,0,7'b1000000}, '{0,0,7'b1000000}, '{0,0,7'b1000000}, '{0,1,7'b1011000},
            // tuser reasserted mid-line restarts the frame
            '{1,0,7'b1100000}, '{0,0,7'b1000000}, '{0,0,7'b1000000}, '{0,1,7'b1010000},
            '{0,0,7'b1000000}, '{1,0,7'b1100001}, '{0,0,7'b1000000}, '{0,0,7'b1000000},
            '{0,1,7'b1010000}, '{0,0,7'b1000000}, '{0,0,7'b1000000}, '{0,0,7'b1000000},
            '{0,1,7'b1011000}
        };
        for (int i = 0; i < 38; i++) begin
            tvalid = 1; tuser = vecs[i].u; tlast = vecs[i].l; tdata = DW'(i * 3 + 1);
            tick();
            check("vector_flags",
                  32'({vld_w[0], fa_w[0], la_w[0], ea_w[0], es_w[0], el_w[0], ee_w[0]}),
                  32'(vecs[i].exp));
            if (vecs[i].exp[6]) check("vector_data", 32'(od_w[0]), 32'(DW'(i * 3 + 1)));
        end
        tvalid = 0; tuser = 0; tlast = 0;
        tick();

        // zero geometry at SOF is rejected
        hact = 16'd0; tvalid = 1; tuser = 1;
        tick();
        check("zero_geom_drop", 32'({vld_w[0], fa_w[0]}), 32'd0);
        hact = 16'd4; tvalid = 0; tuser = 0;
        tick();

        // fsync-armed SOF: beats before fsync dropped, only first post-fsync beat aligns
        for (int i = 0; i < 3; i++) begin
            tvalid = 1; tuser = 1'($urandom); tlast = 0; tdata = DW'($urandom);
            tick();
            check("on_pre_fsync_drop", 32'(vld_w[1]), 32'd0);
        end
        tvalid = 0; fsync = 1;
        tick();
        fsync = 0;
        for (int i = 0; i < 8; i++) begin
            tvalid = 1; tuser = 1'($urandom); tlast = (i % 4 == 3); tdata = DW'($urandom);
            tick();
            check("on_vld", 32'(vld_w[1]), 32'd1);
            check("on_falign", 32'(fa_w[1]), 32'(i == 0));
            check("on_ealign", 32'(ea_w[1]), 32'(i == 7));
        end
        tvalid = 0; tuser = 0; tlast = 0;
        tick();

        // backpressure and clock-enable gaps mid-line
        for (int c = 0; c < 14; c++) begin
            tvalid = 1; tuser = (c == 0); tlast = (c % 4 == 3); tdata = DW'(100 + c);
            afull = (c >= 2 && c <= 4);
            aclken = !(c == 8 || c == 9);
            tick();
            if (c == 2) check("tready_drop", 32'(if_off.axi_tready), 32'd0);
            if (c == 5) check("tready_back", 32'(if_off.axi_tready), 32'd1);
            if (c == 8 || c == 9) check("clken_low_vld", 32'(vld_w[0]), 32'd0);
        end
        afull = 0; aclken = 1; tvalid = 0; tuser = 0; tlast = 0;
        tick();

        // synchronous reset mid-frame
        tvalid = 1; tuser = 1; tdata = DW'(7);
        tick();
        tuser = 0;
        tick();
        rstn = 0;
        tick();
        check("reset_mid_off", pack_act(0), 32'h0);
        check("reset_mid_on", pack_act(1), 32'h0);
        rstn = 1; tvalid = 0;
        tick();
        tick();
        tvalid = 1; tuser = 0;
        tick();
        check("post_reset_wait_sof", 32'(vld_w[0]), 32'd0);
        tvalid = 0;

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rstn   = ($urandom_range(0, 499) != 0);
            aclken = ($urandom_range(0, 9) != 0);
            afull  = ($urandom_range(0, 9) == 0);
            fsync  = ($urandom_range(0, 29) == 0);
            tvalid = ($urandom_range(0, 9) < 7);
            tuser  = ($urandom_range(0, 19) == 0);
            tlast  = ($urandom_range(0, 4) == 0);
            tdata  = DW'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                hact = 16'($urandom_range(0, 5));
                vact = 16'($urandom_range(0, 3));
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/stream_in_port_geom.md
Name: stream_in_port_geom

Overview:
- AXI4-Stream video ingress port; successor to the basic stream input port.
- Converts an AXI video stream into the internal write-side format: data, valid, frame/line/end-of-frame alignment pulses. Feeds the VDMA write FIFO.
- Adds SOF lock-on, per-line geometry checking against hactive/vactive, long-line truncation, and registered outputs with tready backpressure.

Parameters:
- DSIZE, 24: tdata/odata width in bits.
- MODE, "LINE": "LINE" = lalign pulses on every line end; "ONCE" = lalign held 0, lines still counted internally.
- FRAME_SYNC, "OFF": "OFF" = SOF taken from axi_tuser; "ON" = SOF armed by the fsync pulse, tuser ignored.

Ports:
- aclk in 1: sole clock.
- aresetn in 1: reset, synchronous, active-low.
- aclken in 1: clock enable; when low, all state and outputs hold, except odata_vld and the pulse outputs, which are 0.
- vactive in 16: lines per frame, sampled at SOF.
- hactive in 16: beats per line, sampled at SOF.
- fsync in 1: external frame-sync pulse, used only when FRAME_SYNC="ON".
- fifo_almost_full in 1: downstream backpressure.
- axi_tdata in DSIZE: stream data.
- axi_tvalid in 1: stream valid.
- axi_tready out 1: stream ready.
- axi_tuser in 1: start of frame.
- axi_tlast in 1: end of line.
- falign out 1: one-cycle pulse with the first beat of a frame.
- lalign out 1: one-cycle pulse with the last accepted beat of a line (MODE="LINE" only).
- ealign out 1: one-cycle pulse with the last beat of the last line.
- odata_vld out 1: odata valid.
- odata out DSIZE: registered copy of accepted tdata.
- err_short out 1: one-cycle pulse; tlast arrived before hactive beats.
- err_long out 1: one-cycle pulse; hactive beats reached without tlast.
- err_early_sof out 1: one-cycle pulse; SOF arrived before vactive lines completed.

Behaviour:
- Reset: all outputs 0, state WAIT_SOF, counters 0, fsync arm cleared. Reset has priority over aclken.
- axi_tready = ~fifo_almost_full, registered, 1-cycle lag. The downstream FIFO must absorb 2 beats beyond almost_full.
- Beat = axi_tvalid & axi_tready & aclken. Outputs lag the beat by exactly 1 cycle.
- SOF definition:
  - FRAME_SYNC="OFF": a beat with tuser=1.
  - FRAME_SYNC="ON": the first beat after an fsync pulse. fsync sets the arm flag; the SOF beat consumes it. fsync arriving while armed is ignored.
- FSM states: WAIT_SOF, ACTIVE, DISCARD.
  - WAIT_SOF: non-SOF beats accepted and dropped (no odata_vld). On SOF: latch hactive/vactive, hcnt=1, vcnt=0, emit falign+data, go ACTIVE. If the latched hactive==0 or vactive==0, drop the beat and stay in WAIT_SOF.
  - ACTIVE, normal beat: output data, hcnt++.
  - ACTIVE, beat with tlast: hcnt<hactive-1 → err_short. Either way lalign, hcnt=0, vcnt++.
  - ACTIVE, beat with hcnt==hactive-1 and no tlast: output it with lalign, pulse err_long, vcnt++, go DISCARD.
  - DISCARD: beats dropped until a tlast beat (dropped), then return to ACTIVE or WAIT_SOF.
  - Line completing with vcnt==vactive-1: ealign on that beat (coincident with lalign if MODE="LINE"), go WAIT_SOF. If the line ended by hactive without tlast, go DISCARD first, then WAIT_SOF on tlast.
  - SOF seen in ACTIVE or DISCARD: err_early_sof, treat the beat as a new-frame SOF (falign, re-latch geometry, state ACTIVE). An SOF beat that also carries tlast is an SOF plus a line end.
- Width rules: hcnt and vcnt are 16 bits with no wrap. Compare against latched geometry minus 1; geometry 0 is excluded by the SOF check.
- Changes to vactive/hactive mid-frame have no effect until the next SOF.

Decomposition:
- Package stream_in_pkg: FSM state enum (WAIT_SOF, ACTIVE, DISCARD), MODE/FRAME_SYNC string constants, counter width constant CNT_W=16.
- One sub-module, geom_counter: hcnt/vcnt with latch, increment and clear. Outputs line_done, frame_done, short_line and long_line flags.
- FSM and output registers stay in the top module.

Test Plan:
- hactive=4, vactive=2, FRAME_SYNC="OFF", MODE="LINE", clean 8-beat frame with tuser on beat 0 and tlast on beats 3,7 → falign cycle 1, lalign on beats 3,7, ealign on beat 7, 8 odata_vld, no errors.
- Same geometry, tlast on beat 2 → err_short on beat 2, lalign on beat 2, vcnt advances. Next line of 4 beats → ealign.
- 6-beat line with tlast on beat 5 → beats 0–3 output with lalign on beat 3 plus err_long. Beats 4–5 dropped, no odata_vld.
- tuser reasserted mid-line (beat 5 of 8) → err_early_sof plus falign on that beat, new frame completes normally.
- FRAME_SYNC="ON", tuser toggled randomly, fsync pulse then 8 beats → only the first post-fsync beat gives falign. Pre-fsync beats dropped.
- fifo_almost_full high for 3 cycles mid-line, and aclken low 2 cycles → tready low one cycle later, no beat loss or duplication, output order preserved. Synchronous reset mid-frame → all outputs 0 next edge, WAIT_SOF.
